fire3_expand3_bias_seq: RTL and testbench
=========================================

// Module: fire3_expand3_bias_seq
// PURPOSE
// - Sequences post-accumulation bias add for the fire3 expand3x3 layer: 64 biases applied per pixel, channel-major.
// - Accumulator words stream in; channel counter selects the bias; result is shifted, saturated and forwarded.
// - Sits between the expand3 MAC array output and the fire3 concat/writeback stage.
// - Owns layer-level start/done sequencing.
// PARAMETERS
// - NUM_CH    64    output channels per pixel; bias entries consumed cyclically
// - NUM_PIX   3025  pixels per layer run (55x55)
// - ACC_W     32    accumulator and bias width, two's complement
// - OUT_W     16    output activation width, two's complement
// - OUT_SHIFT 0     arithmetic right shift applied after bias add (0..ACC_W-1)
// PORTS
// - clk        in   1            rising-edge clock
// - rst        in   1            synchronous, active-high reset
// - start      in   1            pulse; begins a layer run (honoured only in IDLE)
// - bias_mem   in   ACC_W x NUM_CH  constant bias array from the biasing block
// - acc_valid  in   1            acc_data valid
// - acc_ready  out  1            block accepts acc_data
// - acc_data   in   ACC_W        accumulator result for current channel
// - out_valid  out  1            out_data valid
// - out_ready  in   1            downstream accepts out_data
// - out_data   out  OUT_W        biased, shifted, saturated activation
// - out_ch     out  $clog2(NUM_CH)  channel index of out_data
// - out_last   out  1            out_data is channel NUM_CH-1 of pixel NUM_PIX-1
// - busy       out  1            high in RUN/DRAIN
// - done       out  1            one-cycle pulse when the final word is accepted downstream
// BEHAVIOUR
// - Reset: state=IDLE; ch_cnt=0, pix_cnt=0; acc_ready=0, out_valid=0, out_data=0, out_ch=0, out_last=0, busy=0, done=0.
// - FSM IDLE: acc_ready=0; start -> RUN, counters cleared.
// - RUN: acc_ready = !out_valid || out_ready.
//   - Accept on acc_valid&&acc_ready.
//   - Accepting the last word (ch=NUM_CH-1, pix=NUM_PIX-1) -> DRAIN.
// - DRAIN: acc_ready=0; out_valid&&out_ready -> IDLE with done=1 in that same cycle.
// - start is ignored outside IDLE.
// - Datapath, latency 1:
//   - sum = acc_data + bias_mem[ch_cnt] at ACC_W+1 bits.
//   - Then arithmetic >>> OUT_SHIFT.
//   - Then saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
//   - Registered on accept together with out_ch=ch_cnt and out_last.
// - Output hold: out_data, out_ch and out_last stay stable while out_valid && !out_ready.
// - Counters: ch_cnt increments per accept and wraps NUM_CH-1 -> 0; pix_cnt increments on that wrap.
// - Simultaneous accept + output handshake: new word replaces the old one in the same cycle, so there are no bubbles at full throughput.
// - rst mid-run: immediate return to reset values; any in-flight word is discarded.
// - Overflow: the ACC_W+1 intermediate never wraps; saturation is exact for both signs.
// CONFIGURATION
// - FIRE3_EXPAND3_RELU_EN defined: negative post-saturation results are forced to 0 (fused ReLU).
// - Not defined: signed result passes unchanged; ReLU is done downstream.
// - Latency and handshake are identical in both builds.
// STRUCTURE
// - Shared package fire_pkg:
//   - typedef enum {IDLE,RUN,DRAIN} seq_state_t
//   - ACC_W / OUT_W defaults
//   - sat_fn saturation function
// - One sub-module: fire_bias_sat (combinational add, shift, saturate, optional ReLU); the FSM and counters stay in the top.
// TESTING
// - Reset then start, ch0 acc=1000, bias=-214 (0xFFFFFF2A) -> out_data=786, out_ch=0, latency 1 cycle.
// - acc=0x7FFFFFF0 on ch7 (bias +646) -> out_data=32767; acc=0x80000000 on ch0 -> -32768 (0 with RELU_EN).
// - out_ready=0 for 5 cycles mid-pixel -> acc_ready=0 and out_data held; release -> no word lost or duplicated.
// - NUM_PIX=2, full-rate stream of 128 words -> ch wraps 63->0 once; out_last on word 128; done pulses once; FSM back in IDLE.
// - rst asserted after 40 accepts -> all outputs zero next cycle; new start restarts at ch0/pix0.
// - start pulsed during RUN -> ignored: counters unaffected, single done at end.

Source files
------------

// File: rtl/fire_pkg.sv
// Shared types and helpers for the fire3 expand3 bias sequencer.
// Build option: FIRE3_EXPAND3_RELU_EN enables the fused ReLU in fire_bias_sat.
package fire_pkg;

    localparam int DEF_ACC_W = 32;
    localparam int DEF_OUT_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } seq_state_t;

    // Clamps a wide signed value into the signed range of an out_w-bit word.
    function automatic logic signed [63:0] sat_fn(input logic signed [63:0] v, input int out_w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/fire_bias_sat.sv
// Combinational bias add, arithmetic shift and saturation for one accumulator word.
// Build option: FIRE3_EXPAND3_RELU_EN forces negative results to zero.
module fire_bias_sat
    import fire_pkg::*;
#(
    parameter int ACC_W     = DEF_ACC_W,
    parameter int OUT_W     = DEF_OUT_W,
    parameter int OUT_SHIFT = 0
) (
    input  logic [ACC_W-1:0] acc,
    input  logic [ACC_W-1:0] bias,
    output logic [OUT_W-1:0] res
);

    logic signed [ACC_W:0]   sum;
    logic signed [ACC_W:0]   shifted;
    logic signed [OUT_W-1:0] sat;

    // One extra bit keeps the sum exact for any pair of operands.
    assign sum     = $signed({acc[ACC_W-1], acc}) + $signed({bias[ACC_W-1], bias});
    assign shifted = sum >>> OUT_SHIFT;
    assign sat     = OUT_W'(sat_fn(64'(shifted), OUT_W));

`ifdef FIRE3_EXPAND3_RELU_EN
    assign res = (sat < 0) ? '0 : sat;
`else
    assign res = sat;
`endif

endmodule

// File: rtl/fire3_expand3_bias_seq.sv
// Layer sequencer for the fire3 expand3x3 bias stage: start/done FSM, channel and
// pixel counters, and a one-deep output register. Build option: FIRE3_EXPAND3_RELU_EN.
module fire3_expand3_bias_seq
    import fire_pkg::*;
#(
    parameter int NUM_CH    = 64,
    parameter int NUM_PIX   = 3025,
    parameter int ACC_W     = DEF_ACC_W,
    parameter int OUT_W     = DEF_OUT_W,
    parameter int OUT_SHIFT = 0,
    localparam int CH_W     = (NUM_CH  > 1) ? $clog2(NUM_CH)  : 1,
    localparam int PIX_W    = (NUM_PIX > 1) ? $clog2(NUM_PIX) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [NUM_CH-1:0][ACC_W-1:0]   bias_mem,
    input  logic                           acc_valid,
    output logic                           acc_ready,
    input  logic [ACC_W-1:0]               acc_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [OUT_W-1:0]               out_data,
    output logic [CH_W-1:0]                out_ch,
    output logic                           out_last,
    output logic                           busy,
    output logic                           done,
    output seq_state_t                     state
);

    // Both ports use valid/ready: a word moves on a rising edge where valid && ready;
    // a producer holds valid and its payload stable until that edge.

    logic [CH_W-1:0]  ch_cnt;
    logic [PIX_W-1:0] pix_cnt;
    logic [OUT_W-1:0] res;
    logic             accept;
    logic             ch_wrap;
    logic             is_last;

    fire_bias_sat #(
        .ACC_W     (ACC_W),
        .OUT_W     (OUT_W),
        .OUT_SHIFT (OUT_SHIFT)
    ) u_bias_sat (
        .acc  (acc_data),
        .bias (bias_mem[ch_cnt]),
        .res  (res)
    );

    assign acc_ready = (state == RUN) && (!out_valid || out_ready);
    assign accept    = acc_valid && acc_ready;
    assign ch_wrap   = (ch_cnt == CH_W'(NUM_CH - 1));
    assign is_last   = ch_wrap && (pix_cnt == PIX_W'(NUM_PIX - 1));
    assign busy      = (state != IDLE);
    assign done      = (state == DRAIN) && out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ch_cnt    <= '0;
            pix_cnt   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            out_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= RUN;
                        ch_cnt  <= '0;
                        pix_cnt <= '0;
                    end
                end
                RUN: begin
                    if (accept) begin
                        // A new word may overwrite the one leaving in this same edge.
                        out_valid <= 1'b1;
                        out_data  <= res;
                        out_ch    <= ch_cnt;
                        out_last  <= is_last;
                        if (ch_wrap) begin
                            ch_cnt  <= '0;
                            pix_cnt <= pix_cnt + PIX_W'(1);
                        end else begin
                            ch_cnt <= ch_cnt + CH_W'(1);
                        end
                        if (is_last) state <= DRAIN;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fire3_expand3_bias_seq.sv
// Self-checking bench for fire3_expand3_bias_seq, run with a two-pixel layer.
// Honours FIRE3_EXPAND3_RELU_EN in its reference model.
module tb_fire3_expand3_bias_seq;
    import fire_pkg::*;

    localparam int NUM_CH    = 64;
    localparam int NUM_PIX   = 2;
    localparam int ACC_W     = 32;
    localparam int OUT_W     = 16;
    localparam int OUT_SHIFT = 0;
    localparam int CH_W      = 6;
    localparam int TOTAL     = NUM_CH * NUM_PIX;
    localparam int EW        = OUT_W + CH_W + 1;

    logic                         clk = 1'b0;
    logic                         rst;
    logic                         start;
    logic [NUM_CH-1:0][ACC_W-1:0] bias_mem;
    logic                         acc_valid;
    logic                         acc_ready;
    logic [ACC_W-1:0]             acc_data;
    logic                         out_valid;
    logic                         out_ready;
    logic [OUT_W-1:0]             out_data;
    logic [CH_W-1:0]              out_ch;
    logic                         out_last;
    logic                         busy;
    logic                         done;
    seq_state_t                   state;

    int checks    = 0;
    int failures  = 0;
    int n_acc     = 0;
    int done_cnt  = 0;
    int stall_cnt = 0;
    logic [EW-1:0] exp_q[$];

    fire3_expand3_bias_seq #(
        .NUM_CH(NUM_CH), .NUM_PIX(NUM_PIX), .ACC_W(ACC_W), .OUT_W(OUT_W), .OUT_SHIFT(OUT_SHIFT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .bias_mem(bias_mem),
        .acc_valid(acc_valid), .acc_ready(acc_ready), .acc_data(acc_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_ch(out_ch), .out_last(out_last), .busy(busy), .done(done), .state(state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [OUT_W-1:0] ref_out(input logic [ACC_W-1:0] a, input logic [ACC_W-1:0] b);
        longint s;
        logic [63:0] u;
        s = longint'($signed(a)) + longint'($signed(b));
        s = s >>> OUT_SHIFT;
        if (s > 32767) s = 32767;
        else if (s < -32768) s = -32768;
`ifdef FIRE3_EXPAND3_RELU_EN
        if (s < 0) s = 0;
`endif
        u = s;
        return u[OUT_W-1:0];
    endfunction

    function automatic logic [ACC_W-1:0] rand_acc();
        if ($urandom_range(0, 3) == 0) return $urandom;
        return 32'($urandom_range(0, 200000)) - 32'd100000;
    endfunction

    // ---------------- scoreboard / monitor ----------------
    always @(negedge clk) begin
        logic [EW-1:0] e;
        logic exp_done;
        int ch;
        if (rst) begin
            exp_q.delete();
            n_acc = 0;
        end else begin
            exp_done = out_valid && out_ready && (exp_q.size() > 0) && exp_q[0][0];
            checks++;
            if (done !== exp_done) begin
                failures++;
                $display("FAIL done_pulse got=%b exp=%b t=%0t", done, exp_done, $time);
            end
            if (done === 1'b1) done_cnt++;
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL out_word got=%h exp=none t=%0t", {out_data, out_ch, out_last}, $time);
                end else begin
                    e = exp_q.pop_front();
                    if ({out_data, out_ch, out_last} !== e) begin
                        failures++;
                        $display("FAIL out_word got data=%h ch=%0d last=%b exp data=%h ch=%0d last=%b t=%0t",
                                 out_data, out_ch, out_last, e[EW-1:CH_W+1], e[CH_W:1], e[0], $time);
                    end
                end
            end
            if (acc_valid && acc_ready) begin
                ch = n_acc % NUM_CH;
                exp_q.push_back({ref_out(acc_data, bias_mem[ch]), CH_W'(ch), 1'(n_acc == TOTAL - 1)});
                n_acc = (n_acc + 1) % TOTAL;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_word(input logic [ACC_W-1:0] d);
        int n = 0;
        acc_valid = 1'b1;
        acc_data  = d;
        @(negedge clk);
        while (!acc_ready && n < 200) begin
            stall_cnt++;
            n++;
            @(negedge clk);
        end
        if (!acc_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout got=acc_ready_low exp=accept t=%0t", $time);
        end
        @(posedge clk);
        #1;
        acc_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checks++;
        if (state !== RUN || busy !== 1'b1) begin
            failures++;
            $display("FAIL start_run got state=%0d busy=%b exp state=1 busy=1", state, busy);
        end
    endtask

    task automatic wait_idle(input int done_before);
        int n = 0;
        while (state !== IDLE && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        checks++;
        if (state !== IDLE || busy !== 1'b0) begin
            failures++;
            $display("FAIL end_idle got state=%0d busy=%b exp state=0 busy=0", state, busy);
        end
        checks++;
        if (exp_q.size() != 0 || n_acc != 0) begin
            failures++;
            $display("FAIL drained got pending=%0d n_acc=%0d exp pending=0 n_acc=0", exp_q.size(), n_acc);
        end
        checks++;
        if (done_cnt != done_before + 1) begin
            failures++;
            $display("FAIL done_count got=%0d exp=%0d", done_cnt - done_before, 1);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; start = 1'b0; acc_valid = 1'b1; acc_data = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({out_valid, out_data, out_ch, out_last, busy, done, acc_ready} !== '0 || state !== IDLE) begin
            failures++;
            $display("FAIL reset_state got valid=%b data=%h ch=%0d last=%b busy=%b done=%b rdy=%b st=%0d exp all zero",
                     out_valid, out_data, out_ch, out_last, busy, done, acc_ready, state);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (acc_ready !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL idle_no_accept got rdy=%b valid=%b exp 0 0", acc_ready, out_valid);
        end
        acc_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_first_word();
        pulse_start();
        send_word(32'd1000);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'd786 || out_ch !== 6'd0) begin
            failures++;
            $display("FAIL first_word got valid=%b data=%0d ch=%0d exp valid=1 data=786 ch=0", out_valid, out_data, out_ch);
        end
    endtask

    task automatic test_saturation();
        logic [OUT_W-1:0] neg_exp;
`ifdef FIRE3_EXPAND3_RELU_EN
        neg_exp = 16'h0000;
`else
        neg_exp = 16'h8000;
`endif
        while (n_acc % NUM_CH != 7) send_word(rand_acc());
        send_word(32'h7FFF_FFF0);
        checks++;
        if (out_data !== 16'h7FFF || out_ch !== 6'd7) begin
            failures++;
            $display("FAIL sat_pos got data=%h ch=%0d exp data=7fff ch=7", out_data, out_ch);
        end
        while (n_acc % NUM_CH != 0) send_word(rand_acc());
        send_word(32'h8000_0000);
        checks++;
        if (out_data !== neg_exp || out_ch !== 6'd0) begin
            failures++;
            $display("FAIL sat_neg got data=%h ch=%0d exp data=%h ch=0", out_data, out_ch, neg_exp);
        end
    endtask

    task automatic test_backpressure();
        logic [OUT_W-1:0] held;
        out_ready = 1'b0;
        acc_valid = 1'b1;
        acc_data  = rand_acc();
        held = (exp_q.size() > 0) ? exp_q[0][EW-1:CH_W+1] : '0;
        repeat (5) begin
            @(negedge clk);
            checks++;
            if (acc_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== held) begin
                failures++;
                $display("FAIL stall_hold got rdy=%b valid=%b data=%h exp rdy=0 valid=1 data=%h",
                         acc_ready, out_valid, out_data, held);
            end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send_word(acc_data);
    endtask

    task automatic test_finish_run();
        int d0 = done_cnt;
        int rem = TOTAL - n_acc;
        for (int i = 0; i < rem; i++) send_word(rand_acc());
        wait_idle(d0);
    endtask

    task automatic test_back_to_back();
        int d0 = done_cnt;
        out_ready = 1'b1;
        pulse_start();
        stall_cnt = 0;
        for (int i = 0; i < TOTAL; i++) begin
            if (i == 50) start = 1'b1;
            send_word(rand_acc());
            start = 1'b0;
        end
        checks++;
        if (stall_cnt != 0) begin
            failures++;
            $display("FAIL full_rate got stalls=%0d exp=0", stall_cnt);
        end
        wait_idle(d0);
    endtask

    task automatic test_reset_mid_run();
        int d0;
        pulse_start();
        for (int i = 0; i < 40; i++) send_word(rand_acc());
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({out_valid, out_data, out_ch, out_last, busy, done, acc_ready} !== '0 || state !== IDLE) begin
            failures++;
            $display("FAIL mid_reset got valid=%b data=%h ch=%0d last=%b busy=%b done=%b rdy=%b st=%0d exp all zero",
                     out_valid, out_data, out_ch, out_last, busy, done, acc_ready, state);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        d0 = done_cnt;
        pulse_start();
        send_word(32'd123);
        checks++;
        if (out_ch !== 6'd0 || out_data !== ref_out(32'd123, bias_mem[0])) begin
            failures++;
            $display("FAIL restart_ch0 got ch=%0d data=%h exp ch=0 data=%h", out_ch, out_data, ref_out(32'd123, bias_mem[0]));
        end
        for (int i = 1; i < TOTAL; i++) send_word(rand_acc());
        wait_idle(d0);
    endtask

    initial begin
        for (int i = 0; i < NUM_CH; i++) bias_mem[i] = 32'($urandom_range(0, 40000)) - 32'd20000;
        bias_mem[0] = 32'hFFFF_FF2A;
        bias_mem[7] = 32'd646;
        test_reset();
        test_first_word();
        test_saturation();
        test_backpressure();
        test_finish_run();
        test_back_to_back();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
